// File: rtl/pdm_player_if.sv
// Memory read port between the PDM player and its sample store.
// The player drives the strobe and address; read data returns one cycle later.
interface pdm_player_if;
  logic        mem_rd;
  logic [15:0] maddr;
  logic [31:0] mdata;

  modport master (
    output mem_rd,
    output maddr,
    input  mdata
  );

  modport slave (
    input  mem_rd,
    input  maddr,
    output mdata
  );
endinterface

// File: rtl/pdm_player.sv
// Streams BOUND 32-bit words from memory out as a gapless MSB-first
// PDM bitstream, prefetching each next word one cycle before it is needed.
module pdm_player #(
  parameter logic [15:0] BOUND = 16'd46875
) (
  input  logic         pdm_clk,
  input  logic         rst,
  input  logic [1:0]   ctrl,
  pdm_player_if.master mem,
  output logic         pdm_out,
  output logic [15:0]  didx,
  output logic         bsy,
  output logic         done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    PRIME = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam logic [15:0] LAST = BOUND - 16'd1;

  state_t      state_q, state_d;
  logic [31:0] sreg_q;
  logic [4:0]  bcnt_q;
  logic [15:0] didx_q;
  logic        ctrl0_q;
  logic        done_q;

  logic        abort;
  logic        start;
  logic        more;
  logic        wrd_end;
  logic        rd;

  assign abort   = ctrl[1];
  assign start   = ctrl[0] & ~ctrl0_q;
  assign more    = didx_q < LAST;
  assign wrd_end = bcnt_q == 5'd0;

  // State register
  always_ff @(posedge pdm_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; abort overrides start and completion
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (start) state_d = LOAD;
        LOAD:    state_d = PRIME;
        PRIME:   state_d = RUN;
        RUN:     if (wrd_end && !more) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs: busy flag and the memory read strobe/address
  always_comb begin
    bsy = state_q != IDLE;
    rd  = 1'b0;
    if (!abort) begin
      rd = (state_q == LOAD) ||
           (state_q == RUN && bcnt_q == 5'd1 && more);
    end
    mem.mem_rd = rd;
    mem.maddr  = 16'd0;
    if (rd && state_q == RUN) mem.maddr = didx_q + 16'd1;
  end

  // Shift register, bit/word counters, start edge detect, done pulse
  always_ff @(posedge pdm_clk or negedge rst) begin
    if (!rst) begin
      sreg_q  <= '0;
      bcnt_q  <= 5'd31;
      didx_q  <= '0;
      ctrl0_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ctrl0_q <= ctrl[0];
      done_q  <= 1'b0;
      if (abort) begin
        sreg_q <= '0;
        bcnt_q <= 5'd31;
        didx_q <= '0;
      end else begin
        unique case (state_q)
          PRIME: begin
            sreg_q <= mem.mdata;
            bcnt_q <= 5'd31;
            didx_q <= '0;
          end
          RUN: begin
            if (!wrd_end) begin
              sreg_q <= {sreg_q[30:0], 1'b0};
              bcnt_q <= bcnt_q - 5'd1;
            end else if (more) begin
              sreg_q <= mem.mdata;
              bcnt_q <= 5'd31;
              didx_q <= didx_q + 16'd1;
            end else begin
              sreg_q <= '0;
              bcnt_q <= 5'd31;
              done_q <= 1'b1;
            end
          end
          default: sreg_q <= '0;
        endcase
      end
    end
  end

  assign pdm_out = sreg_q[31];
  assign didx    = didx_q;
  assign done    = done_q;

endmodule

// File: tb/tb_pdm_player.sv
// Directed bench for pdm_player: two instances (BOUND=2 and BOUND=1)
// share clock, reset and control, each with its own memory model.
module tb_pdm_player;

  logic       clk;
  logic       rst;
  logic [1:0] ctrl;

  pdm_player_if m2();
  pdm_player_if m1();

  logic        po2, bs2, dn2;
  logic [15:0] di2;
  logic        po1, bs1, dn1;
  logic [15:0] di1;

  logic [31:0] mem2 [0:3];
  logic [31:0] mem1 [0:3];

  int n_cmp;
  int n_err;

  logic        c_rd2 [0:119];
  logic [15:0] c_ad2 [0:119];
  logic        c_po2 [0:119];
  logic        c_bs2 [0:119];
  logic        c_dn2 [0:119];
  logic [15:0] c_di2 [0:119];
  logic        c_rd1 [0:119];
  logic [15:0] c_ad1 [0:119];
  logic        c_po1 [0:119];
  logic        c_bs1 [0:119];
  logic        c_dn1 [0:119];

  pdm_player #(.BOUND(16'd2)) u_b2 (
    .pdm_clk (clk),
    .rst     (rst),
    .ctrl    (ctrl),
    .mem     (m2.master),
    .pdm_out (po2),
    .didx    (di2),
    .bsy     (bs2),
    .done    (dn2)
  );

  pdm_player #(.BOUND(16'd1)) u_b1 (
    .pdm_clk (clk),
    .rst     (rst),
    .ctrl    (ctrl),
    .mem     (m1.master),
    .pdm_out (po1),
    .didx    (di1),
    .bsy     (bs1),
    .done    (dn1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (m2.mem_rd) m2.mdata <= mem2[m2.maddr[1:0]];
    if (m1.mem_rd) m1.mdata <= mem1[m1.maddr[1:0]];
  end

  // Start a run and record both instances for n cycles (cycle 0 = T)
  task automatic capture(input int n);
    @(posedge clk); #1;
    ctrl[0] = 1'b1;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      c_rd2[k] = m2.mem_rd; c_ad2[k] = m2.maddr;
      c_po2[k] = po2; c_bs2[k] = bs2;
      c_dn2[k] = dn2; c_di2[k] = di2;
      c_rd1[k] = m1.mem_rd; c_ad1[k] = m1.maddr;
      c_po1[k] = po1; c_bs1[k] = bs1;
      c_dn1[k] = dn1;
      if (k == 2) ctrl[0] = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst  = 1'b0;
    ctrl = 2'b00;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({po2, bs2, dn2, m2.mem_rd, m2.maddr, di2} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_b2: got %h want 0",
               {po2, bs2, dn2, m2.mem_rd, m2.maddr, di2});
    end
    n_cmp++;
    if ({po1, bs1, dn1, m1.mem_rd, m1.maddr, di1} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_b1: got %h want 0",
               {po1, bs1, dn1, m1.mem_rd, m1.maddr, di1});
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_main;
    logic [63:0] stream;
    int nrd, ndn, nbs;
    capture(72);
    stream = '0;
    for (int k = 3; k <= 66; k++) stream = {stream[62:0], c_po2[k]};
    nrd = 0; ndn = 0; nbs = 0;
    for (int k = 0; k < 72; k++) begin
      nrd += int'(c_rd2[k]);
      ndn += int'(c_dn2[k]);
      nbs += int'(c_bs2[k]);
    end
    n_cmp++;
    if ({c_rd2[1], c_ad2[1]} !== 17'h1_0000) begin
      n_err++;
      $display("FAIL main_rd0: got %h want 10000", {c_rd2[1], c_ad2[1]});
    end
    n_cmp++;
    if ({c_rd2[33], c_ad2[33]} !== 17'h1_0001) begin
      n_err++;
      $display("FAIL main_rd1: got %h want 10001", {c_rd2[33], c_ad2[33]});
    end
    n_cmp++;
    if (nrd != 2) begin
      n_err++;
      $display("FAIL main_rdcnt: got %0d want 2", nrd);
    end
    n_cmp++;
    if (stream !== 64'h8000_0001_A5A5_A5A5) begin
      n_err++;
      $display("FAIL main_stream: got %h want 80000001a5a5a5a5", stream);
    end
    n_cmp++;
    if ({c_po2[2], c_po2[67]} !== 2'b00) begin
      n_err++;
      $display("FAIL main_edges: got %b want 00", {c_po2[2], c_po2[67]});
    end
    n_cmp++;
    if (c_dn2[67] !== 1'b1 || ndn != 1) begin
      n_err++;
      $display("FAIL main_done: got %b/%0d want 1/1", c_dn2[67], ndn);
    end
    n_cmp++;
    if ({c_bs2[0], c_bs2[1], c_bs2[66], c_bs2[67]} !== 4'b0110 || nbs != 66) begin
      n_err++;
      $display("FAIL main_bsy: got %b/%0d want 0110/66",
               {c_bs2[0], c_bs2[1], c_bs2[66], c_bs2[67]}, nbs);
    end
    n_cmp++;
    if ({c_di2[34], c_di2[35], c_di2[70]} !== {16'd0, 16'd1, 16'd1}) begin
      n_err++;
      $display("FAIL main_didx: got %h want 000000010001",
               {c_di2[34], c_di2[35], c_di2[70]});
    end
  endtask

  task automatic test_bound1;
    int nrd, ndn, nones;
    capture(72);
    nrd = 0; ndn = 0; nones = 0;
    for (int k = 0; k < 72; k++) begin
      nrd   += int'(c_rd1[k]);
      ndn   += int'(c_dn1[k]);
      nones += int'(c_po1[k]);
    end
    n_cmp++;
    if (nrd != 1 || {c_rd1[1], c_ad1[1]} !== 17'h1_0000) begin
      n_err++;
      $display("FAIL b1_rd: got %0d/%h want 1/10000", nrd, {c_rd1[1], c_ad1[1]});
    end
    n_cmp++;
    if (nones != 32 || {c_po1[2], c_po1[3], c_po1[34], c_po1[35]} !== 4'b0110) begin
      n_err++;
      $display("FAIL b1_bits: got %0d/%b want 32/0110", nones,
               {c_po1[2], c_po1[3], c_po1[34], c_po1[35]});
    end
    n_cmp++;
    if (c_dn1[35] !== 1'b1 || ndn != 1 || c_bs1[35] !== 1'b0) begin
      n_err++;
      $display("FAIL b1_done: got %b/%0d want 1/1", c_dn1[35], ndn);
    end
  endtask

  task automatic test_abort;
    int ndn;
    @(posedge clk); #1;
    ctrl[0] = 1'b1;
    for (int k = 0; k <= 33; k++) begin
      @(negedge clk);
      if (k == 2) ctrl[0] = 1'b0;
    end
    n_cmp++;
    if ({m2.mem_rd, m2.maddr} !== 17'h1_0001) begin
      n_err++;
      $display("FAIL abort_pre: got %h want 10001", {m2.mem_rd, m2.maddr});
    end
    ctrl = 2'b10;
    @(negedge clk);
    n_cmp++;
    if ({bs2, m2.mem_rd, po2, dn2, di2} !== 20'd0) begin
      n_err++;
      $display("FAIL abort_post: got %h want 0", {bs2, m2.mem_rd, po2, dn2, di2});
    end
    ctrl = 2'b00;
    ndn = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      ndn += int'(dn2) + int'(dn1);
    end
    n_cmp++;
    if (ndn != 0) begin
      n_err++;
      $display("FAIL abort_nodone: got %0d want 0", ndn);
    end
  endtask

  task automatic test_hold;
    int nrd, ndn;
    @(posedge clk); #1;
    ctrl[0] = 1'b1;
    nrd = 0; ndn = 0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      nrd += int'(m2.mem_rd);
      ndn += int'(dn2);
      if (k == 10) ctrl[0] = 1'b0;
      if (k == 20) ctrl[0] = 1'b1;
    end
    n_cmp++;
    if (nrd != 2 || ndn != 1 || bs2 !== 1'b0) begin
      n_err++;
      $display("FAIL hold_once: got rd=%0d done=%0d bsy=%b want 2/1/0", nrd, ndn, bs2);
    end
    ctrl[0] = 1'b0;
    repeat (3) @(negedge clk);
    capture(80);
    n_cmp++;
    if ({c_rd2[1], c_ad2[1], c_di2[1], c_di2[3]} !== {1'b1, 16'd0, 16'd1, 16'd0}) begin
      n_err++;
      $display("FAIL hold_fresh: got %h want 1000000010000",
               {c_rd2[1], c_ad2[1], c_di2[1], c_di2[3]});
    end
  endtask

  task automatic test_reset_mid;
    int nact;
    mem2[0] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    ctrl[0] = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 2) ctrl[0] = 1'b0;
    end
    n_cmp++;
    if ({po2, bs2} !== 2'b11) begin
      n_err++;
      $display("FAIL rstmid_pre: got %b want 11", {po2, bs2});
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({po2, bs2, dn2, m2.mem_rd, m2.maddr, di2,
         po1, bs1, dn1, m1.mem_rd, m1.maddr, di1} !== 40'd0) begin
      n_err++;
      $display("FAIL rstmid_async: got %h want 0",
               {po2, bs2, dn2, m2.mem_rd, m2.maddr, di2,
                po1, bs1, dn1, m1.mem_rd, m1.maddr, di1});
    end
    @(negedge clk);
    rst = 1'b1;
    nact = 0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      nact += int'(m2.mem_rd) + int'(dn2) + int'(bs2);
      nact += int'(m1.mem_rd) + int'(dn1) + int'(bs1);
    end
    n_cmp++;
    if (nact != 0) begin
      n_err++;
      $display("FAIL rstmid_quiet: got %0d want 0", nact);
    end
    mem2[0] = 32'h8000_0001;
  endtask

  task automatic test_start_abort;
    int nbs;
    @(posedge clk); #1;
    ctrl = 2'b11;
    nbs = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      nbs += int'(bs2) + int'(bs1) + int'(m2.mem_rd);
      if (k == 2) ctrl = 2'b00;
    end
    n_cmp++;
    if (nbs != 0) begin
      n_err++;
      $display("FAIL start_abort: got %0d want 0", nbs);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    mem2[0] = 32'h8000_0001;
    mem2[1] = 32'hA5A5_A5A5;
    mem2[2] = 32'hDEAD_BEEF;
    mem2[3] = 32'hDEAD_BEEF;
    mem1[0] = 32'hFFFF_FFFF;
    mem1[1] = 32'h0F0F_0F0F;
    mem1[2] = 32'h0F0F_0F0F;
    mem1[3] = 32'h0F0F_0F0F;
    m2.mdata = '0;
    m1.mdata = '0;
    test_reset;
    test_main;
    test_bound1;
    test_abort;
    test_hold;
    test_reset_mid;
    test_start_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_player.md
PDM_PLAYER -- requirements
Module: pdm_player

Interface
REQ-001 The block SHALL have parameter BOUND, default 16'd46875, giving the number of 32-bit words played per run (legal range 1..65535).
REQ-002 pdm_clk  input  1  sole clock; all state updates occur on the rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 ctrl  input  2  ctrl[0] start request (rising edge); ctrl[1] abort/clear (level, highest priority).
REQ-005 mdata  input  32  memory read data, valid the cycle after mem_rd is asserted.
REQ-006 mem_rd  output  1  memory read strobe, one cycle per word.
REQ-007 maddr  output  16  memory word address qualified by mem_rd.
REQ-008 pdm_out  output  1  serial PDM bitstream, one bit per pdm_clk, MSB of each word first.
REQ-009 didx  output  16  index of the word currently being shifted out.
REQ-010 bsy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse on normal completion of a run.

Function
REQ-012 The block SHALL implement states IDLE, LOAD, PRIME, RUN.
REQ-013 The block SHALL register ctrl[0] each cycle, with start = ctrl[0] & ~ctrl0_q.
REQ-014 In IDLE with start=1 and ctrl[1]=0, the next state SHALL be LOAD; ctrl[0] held high SHALL NOT retrigger.
REQ-015 LOAD SHALL last one cycle with mem_rd=1 and maddr=0; the next state SHALL be PRIME.
REQ-016 PRIME SHALL last one cycle and SHALL load sreg<=mdata, bcnt<=31, didx<=0; the next state SHALL be RUN.
REQ-017 Latency: start seen at cycle T SHALL give LOAD at T+1, PRIME at T+2, and the first bit (word0[31]) on pdm_out at T+3.
REQ-018 pdm_out SHALL be driven directly from flop sreg[31]; sreg SHALL be 0 whenever the block is not in RUN.
REQ-019 In RUN, each cycle SHALL shift sreg left by one (LSB filled with 0) and decrement bcnt while bcnt is not 0.
REQ-020 In RUN with bcnt==1 and didx<BOUND-1, the block SHALL assert mem_rd for one cycle with maddr=didx+1.
REQ-021 In RUN with bcnt==0 and didx<BOUND-1, the block SHALL load sreg<=mdata, set bcnt<=31, increment didx, and stay in RUN, giving a gapless stream.
REQ-022 In RUN with bcnt==0 and didx==BOUND-1, the next state SHALL be IDLE, sreg SHALL be cleared to 0, and done SHALL pulse for the IDLE entry cycle only.
REQ-023 mem_rd SHALL never be asserted for an address of BOUND or above; when BOUND=1, LOAD is the only read.
REQ-024 Exactly 32*BOUND pdm_out bits SHALL be emitted per completed run.
REQ-025 ctrl[1]=1 in any state SHALL force the next state to IDLE with sreg=0, bcnt=31, didx=0, mem_rd=0, and no done pulse.
REQ-026 Abort SHALL take priority over start and over completion when both occur in the same cycle.
REQ-027 A start edge arriving while bsy=1 SHALL be ignored.
REQ-028 maddr SHALL be 0 whenever mem_rd is 0.
REQ-029 didx SHALL hold its last value in IDLE after a completed run and SHALL be reset to 0 by PRIME.

Reset
REQ-030 rst low SHALL immediately force state=IDLE, sreg=0, bcnt=31, didx=0, ctrl0_q=0, mem_rd=0, maddr=0, pdm_out=0, bsy=0, done=0.
REQ-031 Reset mid-run SHALL abandon the run with no done pulse; after rst is released, a new start edge is required.

Verification
REQ-032 BOUND=2, mem[0]=32'h8000_0001, mem[1]=32'hA5A5_A5A5, start pulse -> the following are all required:
- mem_rd at T+1 (addr 0) and at T+33 (addr 1);
- pdm_out from T+3 reads 1, 30 zeros, 1, then 10100101 repeated with no gap;
- done pulses at T+67; bsy is high for T+1..T+66.
REQ-033 BOUND=1, mem[0]=32'hFFFF_FFFF -> exactly 32 ones on pdm_out, a single mem_rd, done after 32 RUN cycles, no read of address 1.
REQ-034 ctrl[1] asserted during RUN at bcnt==1 -> the next cycle is IDLE, mem_rd=0 in that cycle, pdm_out=0, no done pulse, didx=0.
REQ-035 ctrl[0] held high across completion and a second edge applied while bsy -> exactly one run; a later fresh edge starts a new run at address 0.
REQ-036 rst pulsed low mid-word -> all outputs return to reset values asynchronously; no mem_rd and no done pulse until the next start edge.
REQ-037 start and ctrl[1] asserted together in IDLE -> the block remains in IDLE with bsy=0.
